// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-port signals for the three-way memory arbiter.
// The arbiter uses the slave view; the requesters and the RAM sit on the master view.
interface mem_arbiter_if #(
    parameter int DATA = 18,
    parameter int ADDR = 14
);
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [2:0]        we;
    logic [3*ADDR-1:0] addr;
    logic [3*DATA-1:0] din;
    logic [2:0]        gnt;
    logic [2:0]        rvalid;
    logic [DATA-1:0]   rdata;
    logic              mem_we;
    logic [ADDR-1:0]   mem_addr;
    logic [DATA-1:0]   mem_din;
    logic [DATA-1:0]   mem_dout;

    modport slave (
        input  req, lock, we, addr, din, mem_dout,
        output gnt, rvalid, rdata, mem_we, mem_addr, mem_din
    );

    modport master (
        output req, lock, we, addr, din, mem_dout,
        input  gnt, rvalid, rdata, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous block-RAM port between three requesters,
// with bounded burst hold (lock) and a fixed one-cycle read return.
module mem_arbiter #(
    parameter int DATA     = 18,
    parameter int ADDR     = 14,
    parameter int MAXBURST = 16
) (
    input  logic          clka,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [7:0] MAXB = 8'(MAXBURST);

    logic [1:0] last_q;
    logic [1:0] last_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [2:0] rvalid_q;
    logic [2:0] rvalid_d;

    logic [2:0]      gnt_s;
    logic [1:0]      win_s;
    logic            any_s;
    logic            hold_s;
    logic [1:0]      cand_s;
    logic            hit_s;
    logic            mem_we_s;
    logic [ADDR-1:0] mem_addr_s;
    logic [DATA-1:0] mem_din_s;

    function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
        logic b;
        case (i)
            2'd0:    b = v[0];
            2'd1:    b = v[1];
            2'd2:    b = v[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        logic [1:0] n;
        case (i)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        logic [2:0] o;
        case (i)
            2'd0:    o = 3'b001;
            2'd1:    o = 3'b010;
            2'd2:    o = 3'b100;
            default: o = 3'b000;
        endcase
        return o;
    endfunction

    // Winner selection: burst hold first, otherwise round-robin from last+1.
    // cnt_q is non-zero only when the previous cycle granted last_q; the rotation
    // naturally reaches last_q only when nobody else is requesting.
    always_comb begin
        win_s  = last_q;
        any_s  = 1'b0;
        cand_s = next_idx(last_q);
        hit_s  = 1'b0;
        hold_s = (cnt_q != 8'd0) && bit_at(bus.req, last_q) &&
                 bit_at(bus.lock, last_q) && (cnt_q < MAXB);
        if (!rst_n) begin
            any_s = 1'b0;
        end else if (hold_s) begin
            win_s = last_q;
            any_s = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                hit_s  = !any_s && bit_at(bus.req, cand_s);
                win_s  = hit_s ? cand_s : win_s;
                any_s  = any_s | hit_s;
                cand_s = next_idx(cand_s);
            end
        end
        gnt_s = any_s ? onehot(win_s) : 3'b000;
    end

    // RAM port mux: the granted requester drives the port; requester 0 when idle.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = bus.addr[0 +: ADDR];
        mem_din_s  = bus.din[0 +: DATA];
        if (any_s) begin
            case (win_s)
                2'd1: begin
                    mem_we_s   = bus.we[1];
                    mem_addr_s = bus.addr[ADDR +: ADDR];
                    mem_din_s  = bus.din[DATA +: DATA];
                end
                2'd2: begin
                    mem_we_s   = bus.we[2];
                    mem_addr_s = bus.addr[2*ADDR +: ADDR];
                    mem_din_s  = bus.din[2*DATA +: DATA];
                end
                default: begin
                    mem_we_s   = bus.we[0];
                    mem_addr_s = bus.addr[0 +: ADDR];
                    mem_din_s  = bus.din[0 +: DATA];
                end
            endcase
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Next-state: winner tracking, burst counting (restart at 1 after MAXBURST), read return.
    always_comb begin
        last_d   = any_s ? win_s : last_q;
        rvalid_d = gnt_s & ~bus.we;
        if (!any_s) begin
            cnt_d = 8'd0;
        end else if ((cnt_q != 8'd0) && (win_s == last_q) && (cnt_q < MAXB)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clka) begin
        if (!rst_n) begin
            last_q   <= 2'd2;
            cnt_q    <= 8'd0;
            rvalid_q <= 3'b000;
        end else begin
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A read return still in flight is suppressed as soon as reset is driven.
    assign bus.gnt      = gnt_s;
    assign bus.rvalid   = rvalid_q & {3{rst_n}};
    assign bus.rdata    = bus.mem_dout;
    assign bus.mem_we   = mem_we_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_din  = mem_din_s;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin order, write/read through a RAM model,
// burst hold and expiry, idle behaviour and reset suppression of read returns.
module tb_mem_arbiter;
    localparam int DATA = 18;
    localparam int ADDR = 14;
    localparam int MAXB = 4;

    logic clka = 1'b0;
    logic rst_n;
    int   ncmp = 0;
    int   nbad = 0;

    always #5 clka = ~clka;

    mem_arbiter_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    mem_arbiter #(.DATA(DATA), .ADDR(ADDR), .MAXBURST(MAXB)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA-1:0] ram [0:(1<<ADDR)-1];

    // Synchronous RAM with registered read (read-before-write).
    always @(posedge clka) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clka);
        #1;
    endtask

    task automatic mid();
        @(negedge clka);
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
        bus.req  = r;
        bus.lock = l;
        bus.we   = w;
    endtask

    logic [2:0]      exp_g  [0:3];
    logic [ADDR-1:0] exp_a  [0:3];
    logic [2:0]      exp_b  [0:5];
    logic [2:0]      exp_rv;
    logic [7:0]      exp_c;

    initial begin
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_a = '{14'h0001, 14'h0002, 14'h0003, 14'h0001};
        exp_b = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

        rst_n    = 1'b0;
        bus.addr = {14'h0003, 14'h0002, 14'h0001};
        bus.din  = {18'h00000, 18'h00000, 18'h00ABC};
        drive(3'b111, 3'b000, 3'b111);

        // Reset: no grant, no write, no read return.
        next_cycle();
        mid();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        next_cycle();

        // Round-robin over three readers: 001,010,100,001 with rvalid one cycle later.
        rst_n = 1'b1;
        drive(3'b111, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++) begin
            exp_rv = (k == 0) ? 3'b000 : exp_g[k-1];
            mid();
            chk("rr_gnt", 32'(bus.gnt), 32'(exp_g[k]));
            chk("rr_addr", 32'(bus.mem_addr), 32'(exp_a[k]));
            chk("rr_rvalid", 32'(bus.rvalid), 32'(exp_rv));
            next_cycle();
        end
        drive(3'b000, 3'b000, 3'b000);
        mid();
        chk("rr_tail_gnt", 32'(bus.gnt), 32'h0);
        chk("rr_tail_rvalid", 32'(bus.rvalid), 32'h1);
        next_cycle();

        // Idle for 5 cycles with every we raised: nothing must happen.
        drive(3'b000, 3'b000, 3'b111);
        for (int k = 0; k < 5; k++) begin
            mid();
            chk("idle_gnt", 32'(bus.gnt), 32'h0);
            chk("idle_mem_we", 32'(bus.mem_we), 32'h0);
            chk("idle_rvalid", 32'(bus.rvalid), 32'h0);
            next_cycle();
        end
        // last was 0 before the idle stretch, so requester 1 is next.
        drive(3'b111, 3'b000, 3'b000);
        mid();
        chk("idle_last_gnt", 32'(bus.gnt), 32'h2);
        next_cycle();

        // Requester 1 writes 0x2A5F at 0x0010, requester 2 reads it back next cycle.
        drive(3'b010, 3'b000, 3'b010);
        bus.addr = {14'h0003, 14'h0010, 14'h0001};
        bus.din  = {18'h00000, 18'h02A5F, 18'h00ABC};
        mid();
        chk("wr_gnt", 32'(bus.gnt), 32'h2);
        chk("wr_mem_we", 32'(bus.mem_we), 32'h1);
        chk("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("wr_mem_din", 32'(bus.mem_din), 32'h2A5F);
        chk("wr_rvalid", 32'(bus.rvalid), 32'h2);
        next_cycle();
        drive(3'b100, 3'b000, 3'b000);
        bus.addr = {14'h0010, 14'h0010, 14'h0001};
        mid();
        chk("rd_gnt", 32'(bus.gnt), 32'h4);
        chk("rd_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rd_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("rd_no_wr_rvalid", 32'(bus.rvalid), 32'h0);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        mid();
        chk("ret_gnt", 32'(bus.gnt), 32'h0);
        chk("ret_rvalid", 32'(bus.rvalid), 32'h4);
        chk("ret_rdata", 32'(bus.rdata), 32'h2A5F);
        chk("ret_idle_addr", 32'(bus.mem_addr), 32'h1);
        chk("ret_idle_din", 32'(bus.mem_din), 32'hABC);
        next_cycle();

        // Burst hold with competition: 0 x4, then 1, then 0 again.
        drive(3'b011, 3'b001, 3'b000);
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("burst_gnt", 32'(bus.gnt), 32'(exp_b[k]));
            next_cycle();
        end
        drive(3'b000, 3'b000, 3'b000);
        next_cycle();

        // Lone locked requester: granted every cycle, counter 1,2,3,4,1,...
        drive(3'b001, 3'b001, 3'b000);
        for (int k = 0; k < 10; k++) begin
            exp_c = (k == 0) ? 8'd0 : 8'(((k - 1) % MAXB) + 1);
            mid();
            chk("solo_gnt", 32'(bus.gnt), 32'h1);
            chk("solo_cnt", 32'(dut.cnt_q), 32'(exp_c));
            next_cycle();
        end
        drive(3'b000, 3'b000, 3'b000);
        next_cycle();

        // Read grant to requester 2, then reset: its return must be dropped.
        drive(3'b100, 3'b000, 3'b000);
        mid();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'h4);
        next_cycle();
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000);
        mid();
        chk("rst_drop_rvalid", 32'(bus.rvalid), 32'h0);
        next_cycle();
        drive(3'b111, 3'b000, 3'b111);
        mid();
        chk("rst_hold_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_hold_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_hold_rvalid", 32'(bus.rvalid), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        drive(3'b101, 3'b000, 3'b000);
        mid();
        chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
        next_cycle();
        drive(3'b000, 3'b000, 3'b000);
        mid();
        chk("post_rst_rvalid", 32'(bus.rvalid), 32'h1);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA, default 18, RAM word width in bits.
REQ-002 Parameter ADDR, default 14, RAM address width in bits.
REQ-003 Parameter MAXBURST, default 16, maximum consecutive grants to one locked requester; legal range 1..255.
REQ-004 clka  in  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clka.
REQ-006 req  in  3  per-requester access request; bit i belongs to requester i.
REQ-007 lock  in  3  per-requester burst hold; bit i is meaningful only while req[i] is 1.
REQ-008 we  in  3  per-requester write enable; 1 = write, 0 = read.
REQ-009 addr  in  3*ADDR  packed addresses; requester i uses bits [i*ADDR +: ADDR].
REQ-010 din  in  3*DATA  packed write data; requester i uses bits [i*DATA +: DATA].
REQ-011 gnt  out  3  one-hot or zero grant; the access is performed in the cycle gnt[i] is 1.
REQ-012 rvalid  out  3  one-hot or zero; read data valid for requester i.
REQ-013 rdata  out  DATA  read data shared by all requesters; qualified by rvalid.
REQ-014 mem_we  out  1  write enable to one port of the block RAM.
REQ-015 mem_addr  out  ADDR  address to that RAM port.
REQ-016 mem_din  out  DATA  write data to that RAM port.
REQ-017 mem_dout  in  DATA  registered read data from that RAM port, available one cycle after the address.

Function
REQ-018 gnt shall be combinational from req, the priority pointer and the burst state, with at most one bit set.
REQ-019 mem_we, mem_addr and mem_din shall be combinational muxes of the granted requester's we, addr and din.
REQ-020 With no grant, mem_we shall be 0; mem_addr and mem_din shall hold requester 0's values.
REQ-021 Arbitration shall be round-robin: search order starts at (last+1) mod 3, where last is a 2-bit register holding the most recent winner.
REQ-022 On each cycle with a grant, last shall be updated to the winner's index.
REQ-023 Burst hold: if the previous cycle's winner w still has req[w]=1 and lock[w]=1, and burst count < MAXBURST, w shall be granted again regardless of other requests.
REQ-024 The burst counter (8 bits) shall load 1 on a grant to a new winner, or on any grant after a cycle with no grant.
REQ-025 The burst counter shall increment on each consecutive grant to the same winner and saturate at MAXBURST.
REQ-026 When the count reaches MAXBURST, the next cycle shall perform normal round-robin, excluding w if any other req is 1.
REQ-027 If w is the only requester after the count reaches MAXBURST, w shall be re-granted and the counter restarts at 1.
REQ-028 Read latency shall be exactly 1 cycle: a read granted to i in cycle N gives rvalid[i]=1 in cycle N+1, with rdata equal to mem_dout in cycle N+1.
REQ-029 rvalid shall be registered; rdata shall be a direct pass-through of mem_dout.
REQ-030 A write grant shall produce no rvalid.
REQ-031 A requester shall hold req, we, addr and din stable until it sees gnt; it may drop req in the cycle after gnt.
REQ-032 A request held while another requester is granted shall not be lost; it shall be served within 2*MAXBURST+2 cycles.
REQ-033 Back-to-back reads and writes from different requesters shall be accepted every cycle with no idle bubble.

Reset
REQ-034 While rst_n=0 at a clock edge: last<=2 (requester 0 has first priority after reset), burst counter<=0, rvalid<=0.
REQ-035 In any cycle in which rst_n=0, gnt shall be 0 and mem_we shall be 0.
REQ-036 A read granted in the cycle before reset asserts shall produce no rvalid.

Verification
REQ-037 Reset, then req=3'b111, lock=0, all reads -> gnt sequence 001,010,100,001; each rvalid one cycle after its gnt.
REQ-038 Requester 1 writes 0x2A5F to addr 0x0010; next cycle requester 2 reads addr 0x0010 -> mem_we=1 only in the first cycle; rvalid=3'b100 with rdata=0x2A5F one cycle after the read grant.
REQ-039 MAXBURST=4, req=3'b011, lock[0]=1 -> gnt[0] for 4 cycles, then gnt[1] for 1 cycle, then gnt[0] again.
REQ-040 req=3'b001 with lock[0]=1 held for 10 cycles, MAXBURST=4 -> gnt=001 on every cycle; the counter follows 1,2,3,4,1,2,... with no gap.
REQ-041 rst_n driven low in the cycle after a read grant to requester 2 -> rvalid stays 000; after release, req=3'b101 gives gnt=001 first.
REQ-042 req=0 for 5 cycles -> gnt=000, mem_we=0, rvalid=000, and last unchanged.
